mem_bus_initiator: RTL and testbench

MEM_BUS_INITIATOR -- requirements
Module: mem_bus_initiator

---
 rtl/mem_bus_pkg.sv | 22 ++
 rtl/mem_bus_watchdog.sv | 27 ++
 rtl/mem_bus_initiator.sv | 158 +++++++++++++++
 tb/tb_mem_bus_initiator.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-bus initiator and its watchdog.
package mem_bus_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_ADDR,
        S_LOAD_DATA,
        S_STORE_DATA,
        S_FINISH,
        S_RESP
    } state_t;

    localparam logic [3:0] ACK_IDLE       = 4'b1000;
    localparam logic [3:0] ACK_STORE_DONE = 4'b0001;
    localparam int         DEFAULT_BLOCK_WORDS = 4;

    function automatic logic [31:0] align_down(input logic [31:0] addr, input logic [31:0] bytes);
        return addr & ~(bytes - 32'd1);
    endfunction

endpackage

// File: rtl/mem_bus_watchdog.sv
// Cycle watchdog: counts while enabled, clears on restart, flags the last allowed cycle.
module mem_bus_watchdog #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic enable,
    input  logic restart,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            count_q <= '0;
        else if (!enable || restart)
            count_q <= '0;
        else
            count_q <= count_q + CW'(1);
    end

    // Fires during the final counted cycle so the FSM leaves on the next edge.
    assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_bus_initiator.sv
// Single-request memory-bus initiator: line loads and single-word stores over a shared DATA bus.
// Optional watchdog enabled by defining MEM_BUS_INITIATOR_TIMEOUT_EN.
module mem_bus_initiator
    import mem_bus_pkg::*;
#(
    parameter int BLOCK_WORDS    = DEFAULT_BLOCK_WORDS,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic                     req_store,
    input  logic [31:0]              req_addr,
    input  logic [31:0]              req_wdata,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [BLOCK_WORDS*32-1:0] resp_line,
    output logic                     VALID,
    output logic                     LOAD,
    output logic                     STORE,
    output logic                     ACK_ADDR,
    input  logic                     READY,
    input  logic [3:0]               ACK_DATA,
    input  logic [31:0]              DATA_IN,
    output logic [31:0]              DATA_OUT,
    output logic                     DATA_OE
);
    localparam int         IDX_W     = $clog2(BLOCK_WORDS);
    localparam logic [3:0] LAST_WORD = 4'(BLOCK_WORDS - 1);

    if (BLOCK_WORDS < 2 || BLOCK_WORDS > 8 || (BLOCK_WORDS & (BLOCK_WORDS - 1)) != 0 ||
        TIMEOUT_CYCLES < 2) begin : g_bad_param
        $error("mem_bus_initiator: unsupported BLOCK_WORDS or TIMEOUT_CYCLES");
    end

    state_t state_q, state_d;
    logic                      op_store_q;
    logic [31:0]               addr_q, wdata_q;
    logic [3:0]                cnt_q;
    logic [31:0]               words_q [BLOCK_WORDS];
    logic [BLOCK_WORDS*32-1:0] line_q;
    logic                      capture, timeout;

    assign capture = (state_q == S_LOAD_DATA) && (ACK_DATA == cnt_q);

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
    logic wd_enable, err_q;

    assign wd_enable = (state_q == S_REQ) || (state_q == S_LOAD_DATA) ||
                       (state_q == S_STORE_DATA) || (state_q == S_FINISH);

    mem_bus_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .enable  (wd_enable),
        .restart (state_d != state_q),
        .expired (timeout)
    );

    // A timeout jumps straight to RESP, so the flag lines up with that single cycle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) err_q <= 1'b0;
        else        err_q <= timeout;
    end

    assign resp_err = (state_q == S_RESP) && err_q;
`else
    assign timeout  = 1'b0;
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:       if (req_valid) state_d = S_REQ;
            S_REQ:        if (READY) state_d = S_ADDR;
            S_ADDR:       state_d = op_store_q ? S_STORE_DATA : S_LOAD_DATA;
            S_LOAD_DATA:  if (capture && cnt_q == LAST_WORD) state_d = S_FINISH;
            S_STORE_DATA: if (ACK_DATA == ACK_STORE_DONE) state_d = S_FINISH;
            S_FINISH:     if (!READY) state_d = S_RESP;
            S_RESP:       state_d = S_IDLE;
            default:      state_d = S_IDLE;
        endcase
        if (timeout) state_d = S_RESP;
    end

    always_comb begin
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        VALID      = 1'b0;
        LOAD       = 1'b0;
        STORE      = 1'b0;
        ACK_ADDR   = 1'b0;
        DATA_OE    = 1'b0;
        DATA_OUT   = '0;
        if (state_q == S_REQ || state_q == S_ADDR ||
            state_q == S_LOAD_DATA || state_q == S_STORE_DATA) begin
            VALID = 1'b1;
            LOAD  = !op_store_q;
            STORE = op_store_q;
        end
        unique case (state_q)
            S_IDLE: req_ready = 1'b1;
            S_ADDR: begin
                ACK_ADDR = 1'b1;
                DATA_OE  = 1'b1;
                DATA_OUT = op_store_q ? align_down(addr_q, 32'd4)
                                      : align_down(addr_q, 32'(BLOCK_WORDS * 4));
            end
            S_STORE_DATA: begin
                DATA_OE  = 1'b1;
                DATA_OUT = wdata_q;
            end
            S_RESP:  resp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (state_q == S_IDLE && req_valid) begin
            op_store_q <= req_store;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
        end
        if (capture)
            words_q[cnt_q[IDX_W-1:0]] <= DATA_IN;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            cnt_q <= '0;
        else if (state_q == S_ADDR)
            cnt_q <= '0;
        else if (capture)
            cnt_q <= cnt_q + 4'd1;
    end

    always_comb begin
        line_q = '0;
        for (int k = 0; k < BLOCK_WORDS; k++)
            line_q[32*k +: 32] = words_q[k];
    end

    // Words are staged separately so resp_line only changes when a load fully completes.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
            resp_line <= '0;
        else if (state_q == S_FINISH && state_d == S_RESP && !op_store_q && !timeout)
            resp_line <= line_q;
    end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Scoreboard bench for mem_bus_initiator with a reactive memory-bus model.
module tb_mem_bus_initiator;
    localparam int         BW       = 4;
    localparam logic [3:0] ACK_IDLE = 4'h8;

    typedef struct {
        logic            err;
        logic [BW*32-1:0] line;
        int              lat;
    } resp_t;

    logic            CLK, RST_N;
    logic            req_valid, req_ready, req_store;
    logic [31:0]     req_addr, req_wdata;
    logic            resp_valid, resp_err;
    logic [BW*32-1:0] resp_line;
    logic            VALID, LOAD, STORE, ACK_ADDR, READY, DATA_OE;
    logic [3:0]      ACK_DATA;
    logic [31:0]     DATA_IN, DATA_OUT;

    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    resp_t       exp_q[$];
    logic [31:0] exp_addr_q[$];
    int          acc_q[$];
    int          acc_hist[$];
    logic [31:0] exp_wdata;

    int          ready_delay;
    logic [3:0]  ack_seq [32];
    int          ack_i, wait_cnt;
    logic        granted;
    logic [31:0] mem_words [8];

    mem_bus_initiator #(.BLOCK_WORDS(BW), .TIMEOUT_CYCLES(16)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
        .VALID(VALID), .LOAD(LOAD), .STORE(STORE), .ACK_ADDR(ACK_ADDR),
        .READY(READY), .ACK_DATA(ACK_DATA), .DATA_IN(DATA_IN),
        .DATA_OUT(DATA_OUT), .DATA_OE(DATA_OE)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial forever begin
        @(posedge CLK);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "bench time limit");
    end

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Memory target: drives READY/ACK_DATA/DATA_IN just after each edge.
    initial begin
        READY = 1'b0; ACK_DATA = ACK_IDLE; DATA_IN = '0;
        granted = 1'b0; wait_cnt = 0; ack_i = 0;
        forever begin
            @(posedge CLK);
            #1;
            if (!RST_N) begin
                READY = 1'b0; ACK_DATA = ACK_IDLE; DATA_IN = '0;
                granted = 1'b0; wait_cnt = 0; ack_i = 0;
            end else if (ACK_ADDR) begin
                ack_i = 0;
                ACK_DATA = ACK_IDLE;
            end else if (VALID && !granted) begin
                if (wait_cnt >= ready_delay) begin
                    READY = 1'b1;
                    granted = 1'b1;
                end else begin
                    wait_cnt++;
                end
            end else if (VALID && granted) begin
                ACK_DATA = (ack_i < 32) ? ack_seq[ack_i] : ACK_IDLE;
                DATA_IN  = ACK_DATA[3] ? 32'h0 : mem_words[ACK_DATA[2:0]];
                ack_i++;
            end else begin
                READY = 1'b0; ACK_DATA = ACK_IDLE; DATA_IN = '0;
                granted = 1'b0; wait_cnt = 0; ack_i = 0;
            end
        end
    end

    // Accept monitor
    initial forever begin
        @(negedge CLK);
        if (RST_N && req_valid && req_ready) begin
            acc_q.push_back(cyc);
            acc_hist.push_back(cyc);
        end
    end

    // Address phase and bus ownership monitor
    initial forever begin
        @(negedge CLK);
        if (RST_N && ACK_ADDR) begin
            if (exp_addr_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL addr_phase: got unexpected ACK_ADDR, required none");
            end else begin
                chk("addr_phase", DATA_OUT, exp_addr_q.pop_front());
                chk("addr_oe", DATA_OE, 1'b1);
            end
        end else if (RST_N && DATA_OE) begin
            chk("oe_owner_store", {VALID, STORE}, 2'b11);
            chk("store_wdata", DATA_OUT, exp_wdata);
        end
    end

    // Response scoreboard
    initial forever begin
        resp_t e;
        int    a;
        @(negedge CLK);
        if (RST_N && resp_valid) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL resp_unexpected: got resp_valid, required none");
            end else begin
                e = exp_q.pop_front();
                a = (acc_q.size() > 0) ? acc_q.pop_front() : -1000;
                chk("resp_err", resp_err, e.err);
                chk("resp_line", resp_line, e.line);
                chk("resp_latency", cyc - a, e.lat);
                chk("resp_bus_quiet", {VALID, DATA_OE, ACK_ADDR}, 3'b000);
            end
        end
    end

    task automatic set_mem(input int delay, input int n, input logic [127:0] nib, input logic [31:0] base);
        ready_delay = delay;
        for (int k = 0; k < 32; k++)
            ack_seq[k] = (k < n) ? nib[4*k +: 4] : ACK_IDLE;
        for (int k = 0; k < 8; k++)
            mem_words[k] = base + 32'(k);
    endtask

    task automatic issue(input logic store, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic push_addr, input logic [31:0] exp_addr,
                         input logic push_resp, input logic err, input logic [127:0] line,
                         input int lat);
        resp_t e;
        e.err = err; e.line = line; e.lat = lat;
        if (push_resp) exp_q.push_back(e);
        if (push_addr) exp_addr_q.push_back(exp_addr);
        exp_wdata = wdata;
        @(posedge CLK); #1;
        req_valid = 1'b1; req_store = store; req_addr = addr; req_wdata = wdata;
        @(posedge CLK); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && req_ready) && n < 300) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL %s: got no response within 300 cycles, required response", tag);
        end
    endtask

    initial begin
        int base, n;
        RST_N = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
        exp_wdata = '0;
        set_mem(0, 0, '0, '0);

        repeat (2) @(negedge CLK);
        chk("reset_bus", {VALID, LOAD, STORE, ACK_ADDR, DATA_OE}, 5'b0);
        chk("reset_resp", {resp_valid, resp_err}, 2'b0);
        chk("reset_data_out", DATA_OUT, 32'h0);
        chk("reset_resp_line", resp_line, 128'h0);
        chk("reset_req_ready", req_ready, 1'b1);
        @(posedge CLK); #3;
        RST_N = 1'b1;

        // Zero-wait line load
        set_mem(0, 4, 128'h3210, 32'hA0);
        issue(1'b0, 32'h0000_0014, 32'h0, 1'b1, 32'h0000_0010, 1'b1, 1'b0,
              128'h000000A3_000000A2_000000A1_000000A0, 8);
        wait_done("load_a");

        // Store with three idle ack cycles; resp_line must not change
        set_mem(0, 4, 128'h1888, 32'h50);
        issue(1'b1, 32'h0000_0102, 32'hDEAD_BEEF, 1'b1, 32'h0000_0100, 1'b1, 1'b0,
              128'h000000A3_000000A2_000000A1_000000A0, 8);
        wait_done("store");

        // Idle acks and a stray out-of-order index
        set_mem(0, 7, 128'h3231880, 32'hB0);
        issue(1'b0, 32'h0000_1234, 32'h0, 1'b1, 32'h0000_1230, 1'b1, 1'b0,
              128'h000000B3_000000B2_000000B1_000000B0, 11);
        wait_done("load_stray");

        // Memory holds READY low for two REQ cycles
        set_mem(2, 4, 128'h3210, 32'hC0);
        issue(1'b0, 32'h0000_003C, 32'h0, 1'b1, 32'h0000_0030, 1'b1, 1'b0,
              128'h000000C3_000000C2_000000C1_000000C0, 10);
        wait_done("load_ready_wait");

        // Asynchronous reset after the second word of a load
        set_mem(0, 2, 128'h10, 32'hD0);
        issue(1'b0, 32'h0000_0040, 32'h0, 1'b1, 32'h0000_0040, 1'b0, 1'b0, '0, 0);
        n = 0;
        while (ack_i < 2 && n < 50) begin
            @(posedge CLK); #2;
            n++;
        end
        @(posedge CLK); #3;
        RST_N = 1'b0;
        #1;
        acc_q.delete();
        chk("midrst_bus", {VALID, LOAD, STORE, ACK_ADDR, DATA_OE}, 5'b0);
        chk("midrst_resp", {resp_valid, resp_err}, 2'b0);
        chk("midrst_data_out", DATA_OUT, 32'h0);
        chk("midrst_resp_line", resp_line, 128'h0);
        chk("midrst_req_ready", req_ready, 1'b1);
        repeat (2) @(posedge CLK);
        #3;
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            chk("post_reset_quiet", {VALID, LOAD, STORE, ACK_ADDR, DATA_OE, resp_valid}, 6'b0);
        end
        set_mem(0, 4, 128'h3210, 32'hE0);
        issue(1'b0, 32'h0000_0044, 32'h0, 1'b1, 32'h0000_0040, 1'b1, 1'b0,
              128'h000000E3_000000E2_000000E1_000000E0, 8);
        wait_done("load_after_reset");

        // req_valid held high: back-to-back accepts spaced by a full transaction
        set_mem(0, 4, 128'h3210, 32'hF0);
        for (int i = 0; i < 2; i++) begin
            resp_t e;
            e.err = 1'b0; e.line = 128'h000000F3_000000F2_000000F1_000000F0; e.lat = 8;
            exp_q.push_back(e);
            exp_addr_q.push_back(32'h0000_0080);
        end
        base = acc_hist.size();
        @(posedge CLK); #1;
        req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h0000_0080; req_wdata = '0;
        n = 0;
        while (acc_hist.size() < base + 2 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(posedge CLK); #1;
        req_valid = 1'b0;
        wait_done("held_req");
        chk("held_accept_count", acc_hist.size() - base, 2);
        if (acc_hist.size() >= base + 2)
            chk("held_accept_gap", acc_hist[base+1] - acc_hist[base], 9);

`ifdef MEM_BUS_INITIATOR_TIMEOUT_EN
        // READY never comes: watchdog answers with an error after 16 REQ cycles
        set_mem(1000, 0, '0, 32'h0);
        issue(1'b0, 32'h0000_0200, 32'h0, 1'b0, 32'h0, 1'b1, 1'b1,
              128'h000000F3_000000F2_000000F1_000000F0, 17);
        wait_done("timeout");
`endif

        repeat (3) @(negedge CLK);
        chk("resp_line_hold", resp_line, 128'h000000F3_000000F2_000000F1_000000F0);
        chk("addr_queue_drained", exp_addr_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
